// File: rtl/macc_relu_sat.sv
// Streaming neuron MAC: lane products summed per beat, accumulated per frame,
// then bias add, optional ReLU and saturation, with valid/ready on both sides.
module macc_relu_sat #(
  parameter int unsigned PARALLEL_IN = 4,
  parameter int unsigned DATA1_WIDTH = 16,
  parameter int unsigned DATA1_INT   = 2,
  parameter int unsigned DATA2_WIDTH = 16,
  parameter int unsigned DATA2_INT   = 2,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned BIAS_WIDTH  = 16,
  parameter int unsigned BIAS_INT    = 4,
  parameter int unsigned DOUT_WIDTH  = 16,
  parameter int unsigned DOUT_INT    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PARALLEL_IN*DATA1_WIDTH-1:0] din1,
  input  logic [PARALLEL_IN*DATA2_WIDTH-1:0] din2,
  input  logic                               din_valid,
  output logic                               din_ready,
  input  logic                               last,
  input  logic [BIAS_WIDTH-1:0]              bias,
  input  logic                               relu_en,
  output logic [DOUT_WIDTH-1:0]              dout,
  output logic                               dout_sat,
  output logic                               dout_valid,
  input  logic                               dout_ready
);

  localparam int unsigned F   = (DATA1_WIDTH - DATA1_INT) + (DATA2_WIDTH - DATA2_INT);
  localparam int unsigned PW  = DATA1_WIDTH + DATA2_WIDTH;
  localparam int unsigned SW  = PW + int'($clog2(PARALLEL_IN));
  localparam int unsigned BSH = F - (BIAS_WIDTH - BIAS_INT);
  localparam int unsigned BXW = BIAS_WIDTH + BSH;
  localparam int unsigned VW  = ((ACC_WIDTH > BXW) ? ACC_WIDTH : BXW) + 1;
  localparam int unsigned TSH = F - (DOUT_WIDTH - DOUT_INT);
  localparam int unsigned TW  = VW - TSH;

  localparam logic signed [TW-1:0] DMAX = {{(TW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] DMIN = ~DMAX;

  logic                          rdy_q, rdy_d;
  logic                          accept;

  logic signed [PW-1:0]          prod_q [PARALLEL_IN];
  logic signed [PW-1:0]          prod_d [PARALLEL_IN];
  logic                          v1_q, last1_q, relu1_q;
  logic signed [BIAS_WIDTH-1:0]  bias1_q;

  logic signed [SW-1:0]          sum_q, sum_d;
  logic                          v2_q, last2_q, relu2_q;
  logic signed [BIAS_WIDTH-1:0]  bias2_q;

  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          first_q, first_d;
  logic                          fin3_q, relu3_q;
  logic signed [BIAS_WIDTH-1:0]  bias3_q;

  logic signed [VW-1:0]          val_q, val_d;
  logic                          fin4_q;

  logic signed [TW-1:0]          trunc;
  logic [DOUT_WIDTH-1:0]         dout_q, dout_d;
  logic                          sat_q, sat_d;
  logic                          dv_q, dv_d;

  assign accept     = din_valid && rdy_q;
  assign din_ready  = rdy_q;
  assign dout       = dout_q;
  assign dout_sat   = sat_q;
  assign dout_valid = dv_q;

  // Lane products at full precision
  always_comb begin
    logic signed [PW-1:0] a, b;
    for (int k = 0; k < int'(PARALLEL_IN); k++) begin
      a         = PW'($signed(din1[k*DATA1_WIDTH +: DATA1_WIDTH]));
      b         = PW'($signed(din2[k*DATA2_WIDTH +: DATA2_WIDTH]));
      prod_d[k] = a * b;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < int'(PARALLEL_IN); k++) begin
      sum_d = sum_d + SW'(prod_q[k]);
    end
  end

  // First beat of a frame restarts the accumulator
  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (v2_q) begin
      acc_d   = first_q ? ACC_WIDTH'(sum_q) : acc_q + ACC_WIDTH'(sum_q);
      first_d = last2_q;
    end
  end

  always_comb begin
    val_d = VW'(acc_q) + (VW'(bias3_q) <<< BSH);
    if (relu3_q && (val_d < 0)) val_d = '0;
  end

  // Floor truncation then clip to the output range
  always_comb begin
    trunc  = TW'(val_q >>> TSH);
    dout_d = DOUT_WIDTH'(trunc);
    sat_d  = 1'b0;
    if (trunc > DMAX) begin
      dout_d = DOUT_WIDTH'(DMAX);
      sat_d  = 1'b1;
    end else if (trunc < DMIN) begin
      dout_d = DOUT_WIDTH'(DMIN);
      sat_d  = 1'b1;
    end
  end

  // One frame in flight: input closes on last, reopens after the result transfer
  always_comb begin
    rdy_d = rdy_q;
    dv_d  = dv_q;
    if (accept && last) rdy_d = 1'b0;
    else if (dv_q && dout_ready) rdy_d = 1'b1;
    if (dv_q && dout_ready) dv_d = 1'b0;
    if (fin4_q) dv_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b1;
      for (int k = 0; k < int'(PARALLEL_IN); k++) prod_q[k] <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      relu1_q <= 1'b0;
      bias1_q <= '0;
      sum_q   <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      relu2_q <= 1'b0;
      bias2_q <= '0;
      acc_q   <= '0;
      first_q <= 1'b1;
      fin3_q  <= 1'b0;
      relu3_q <= 1'b0;
      bias3_q <= '0;
      val_q   <= '0;
      fin4_q  <= 1'b0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      rdy_q   <= rdy_d;
      dv_q    <= dv_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      fin3_q  <= v2_q && last2_q;
      fin4_q  <= fin3_q;
      if (accept) begin
        prod_q  <= prod_d;
        last1_q <= last;
      end
      if (accept && last) begin
        bias1_q <= $signed(bias);
        relu1_q <= relu_en;
      end
      if (v1_q) begin
        sum_q   <= sum_d;
        last2_q <= last1_q;
        bias2_q <= bias1_q;
        relu2_q <= relu1_q;
      end
      if (v2_q && last2_q) begin
        bias3_q <= bias2_q;
        relu3_q <= relu2_q;
      end
      if (fin3_q) val_q <= val_d;
      if (fin4_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

endmodule
